// File: rtl/vga_timing_gen_if.sv
// Pixel-side raster bus shared by the timing generator and the sprite/palette renderers.
// The generator drives it through the master modport; renderers listen on the slave modport.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, active-low syncs, visible flag and line/frame strobes.
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by one flop to align with registered colour.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Phase boundaries are 11 bits wide so a visible region of 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_FP_END   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_FP_END   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_VISIBLE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  function automatic phase_e phase_of(
    input logic [9:0]  cnt,
    input logic [10:0] vis_end,
    input logic [10:0] fp_end,
    input logic [10:0] sync_end
  );
    logic [10:0] c;
    c = {1'b0, cnt};
    if (c < vis_end)       return PH_VISIBLE;
    else if (c < fp_end)   return PH_FRONT;
    else if (c < sync_end) return PH_SYNC;
    else                   return PH_BACK;
  endfunction

  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  phase_e     h_ph_nxt;
  phase_e     v_ph_nxt;

  logic blank_q;
  logic hs_q;
  logic vs_q;
  logic line_start_q;
  logic frame_start_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch can be inferred.
  always_comb begin
    x_nxt = x_q + 10'd1;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
    h_ph_nxt = phase_of(x_nxt, H_VIS_END, H_FP_END, H_SYNC_END);
    v_ph_nxt = phase_of(y_nxt, V_VIS_END, V_FP_END, V_SYNC_END);
  end

  // Outputs are decoded from the next counter values so they line up with DrawX/DrawY.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_nxt;
      y_q           <= y_nxt;
      blank_q       <= (h_ph_nxt == PH_VISIBLE) && (v_ph_nxt == PH_VISIBLE);
      hs_q          <= (h_ph_nxt != PH_SYNC);
      vs_q          <= (v_ph_nxt != PH_SYNC);
      line_start_q  <= (x_nxt == '0);
      frame_start_q <= (x_nxt == '0) && (y_nxt == '0);
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q;
  logic vs_dly_q;

  // Extra stage so syncs line up with a consumer that registers colour one cycle later.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
    end
  end

  assign vga.hs = hs_dly_q;
  assign vga.vs = vs_dly_q;
`else
  assign vga.hs = hs_q;
  assign vga.vs = vs_q;
`endif

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.blank       = blank_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
